// File: rtl/memory_access_if.sv
// Bundles the three handshakes around the MEM stage: EX_MEM in, data-memory bus, MEM_WB out.
interface memory_access_if;
  // EX_MEM side
  logic        ex_mem_valid;
  logic        ex_mem_ready;
  logic [31:0] ex_mem_alu_out;
  logic [31:0] ex_mem_b;
  logic [31:0] ex_mem_ir;
  logic [31:0] ex_mem_pc;
  // data-memory bus
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  // MEM_WB side
  logic        mem_wb_valid;
  logic [31:0] mem_wb_ir;
  logic [31:0] mem_wb_pc;
  logic [31:0] mem_wb_alu_out;
  logic [31:0] mem_wb_lmd;
  logic        mem_wb_misalign;
  logic        mem_wb_bus_err;

  // The MEM stage itself.
  modport master (
    input  ex_mem_valid, ex_mem_alu_out, ex_mem_b, ex_mem_ir, ex_mem_pc,
    input  dmem_rdata, dmem_ack,
    output ex_mem_ready,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output mem_wb_valid, mem_wb_ir, mem_wb_pc, mem_wb_alu_out, mem_wb_lmd,
    output mem_wb_misalign, mem_wb_bus_err
  );

  // Everything around it: EX stage, data memory and write-back.
  modport slave (
    output ex_mem_valid, ex_mem_alu_out, ex_mem_b, ex_mem_ir, ex_mem_pc,
    output dmem_rdata, dmem_ack,
    input  ex_mem_ready,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  mem_wb_valid, mem_wb_ir, mem_wb_pc, mem_wb_alu_out, mem_wb_lmd,
    input  mem_wb_misalign, mem_wb_bus_err
  );
endinterface

// File: rtl/memory_access.sv
// MEM stage of the RV32I core: runs loads/stores over a req/ack bus, passes
// everything else through in one cycle, and produces the MEM_WB register set.
//
// state | meaning
// IDLE  | ready for a new instruction from EX
// REQ   | bus request outstanding, waiting for ack or timeout
// DONE  | MEM_WB outputs just updated, valid pulse high
module memory_access #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic           clk,
  input logic           rst,
  memory_access_if.master bus
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   tmo_cnt;
  logic [31:0]        ir_q;
  logic [31:0]        pc_q;
  logic [31:0]        alu_q;

  logic [2:0]  in_f3;
  logic [1:0]  in_a;
  logic        in_load;
  logic        in_store;
  logic        in_mem;
  logic        in_misalign;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;

  // Decode the incoming instruction into bus controls and alignment status.
  always_comb begin
    in_f3       = bus.ex_mem_ir[14:12];
    in_a        = bus.ex_mem_alu_out[1:0];
    in_load     = (bus.ex_mem_ir[6:0] == OP_LOAD) &&
                  (in_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    in_store    = (bus.ex_mem_ir[6:0] == OP_STORE) &&
                  (in_f3 inside {3'b000, 3'b001, 3'b010});
    in_mem      = in_load | in_store;
    in_misalign = 1'b0;
    if (in_mem) begin
      case (in_f3[1:0])
        2'b01:   in_misalign = in_a[0];
        2'b10:   in_misalign = (in_a != 2'b00);
        default: in_misalign = 1'b0;
      endcase
    end
    in_be    = 4'b1111;
    in_wdata = bus.ex_mem_b;
    if (in_store) begin
      case (in_f3[1:0])
        2'b00: begin
          in_be    = 4'b0001 << in_a;
          in_wdata = {4{bus.ex_mem_b[7:0]}};
        end
        2'b01: begin
          in_be    = 4'b0011 << in_a;
          in_wdata = {2{bus.ex_mem_b[15:0]}};
        end
        default: ;
      endcase
    end
  end

  logic [31:0] rd_shift;
  logic [31:0] load_data;

  // Pull the addressed lane down to bit 0 and sign/zero extend it.
  always_comb begin
    rd_shift = bus.dmem_rdata >> {alu_q[1:0], 3'b000};
    case (ir_q[14:12])
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  load_data = rd_shift;
      3'b100:  load_data = {24'h0, rd_shift[7:0]};
      3'b101:  load_data = {16'h0, rd_shift[15:0]};
      default: load_data = 32'h0;
    endcase
  end

  // Stage FSM; all bus and MEM_WB outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      tmo_cnt             <= '0;
      ir_q                <= 32'h0;
      pc_q                <= 32'h0;
      alu_q               <= 32'h0;
      bus.ex_mem_ready    <= 1'b1;
      bus.dmem_req        <= 1'b0;
      bus.dmem_we         <= 1'b0;
      bus.dmem_addr       <= 32'h0;
      bus.dmem_wdata      <= 32'h0;
      bus.dmem_be         <= 4'h0;
      bus.mem_wb_valid    <= 1'b0;
      bus.mem_wb_ir       <= 32'h0;
      bus.mem_wb_pc       <= 32'h0;
      bus.mem_wb_alu_out  <= 32'h0;
      bus.mem_wb_lmd      <= 32'h0;
      bus.mem_wb_misalign <= 1'b0;
      bus.mem_wb_bus_err  <= 1'b0;
    end else begin
      bus.mem_wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ex_mem_valid) begin
            bus.ex_mem_ready <= 1'b0;
            ir_q             <= bus.ex_mem_ir;
            pc_q             <= bus.ex_mem_pc;
            alu_q            <= bus.ex_mem_alu_out;
            if (in_mem && !in_misalign) begin
              state          <= REQ;
              tmo_cnt        <= '0;
              bus.dmem_req   <= 1'b1;
              bus.dmem_we    <= in_store;
              bus.dmem_addr  <= {bus.ex_mem_alu_out[31:2], 2'b00};
              bus.dmem_be    <= in_be;
              bus.dmem_wdata <= in_wdata;
            end else begin
              state               <= DONE;
              bus.mem_wb_valid    <= 1'b1;
              bus.mem_wb_ir       <= bus.ex_mem_ir;
              bus.mem_wb_pc       <= bus.ex_mem_pc;
              bus.mem_wb_alu_out  <= bus.ex_mem_alu_out;
              bus.mem_wb_lmd      <= 32'h0;
              bus.mem_wb_misalign <= in_misalign;
              bus.mem_wb_bus_err  <= 1'b0;
            end
          end
        end
        REQ: begin
          if (bus.dmem_ack || (tmo_cnt == CNT_LAST)) begin
            state               <= DONE;
            bus.dmem_req        <= 1'b0;
            bus.dmem_we         <= 1'b0;
            bus.dmem_addr       <= 32'h0;
            bus.dmem_be         <= 4'h0;
            bus.dmem_wdata      <= 32'h0;
            bus.mem_wb_valid    <= 1'b1;
            bus.mem_wb_ir       <= ir_q;
            bus.mem_wb_pc       <= pc_q;
            bus.mem_wb_alu_out  <= alu_q;
            bus.mem_wb_lmd      <= (bus.dmem_ack && !bus.dmem_we) ? load_data : 32'h0;
            bus.mem_wb_misalign <= 1'b0;
            bus.mem_wb_bus_err  <= !bus.dmem_ack;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          state            <= IDLE;
          bus.ex_mem_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for the MEM stage: each scenario pushes the expected MEM_WB
// record when it drives an instruction and pops it when the valid pulse appears.
module tb_memory_access;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_access_if bus();

  memory_access #(.TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] lmd;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Observations collected by run_op
  int          obs_lat;
  int          obs_req;
  bit          obs_stable;
  bit          obs_pulse1;
  logic        obs_ready;
  logic        obs_we;
  logic [31:0] obs_addr;
  logic [31:0] obs_wdata;
  logic [3:0]  obs_be;

  function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [2:0] f3);
    return {17'h0, f3, 5'd1, op};
  endfunction

  function automatic logic [129:0] wb_now();
    return {bus.mem_wb_ir, bus.mem_wb_pc, bus.mem_wb_alu_out, bus.mem_wb_lmd,
            bus.mem_wb_misalign, bus.mem_wb_bus_err};
  endfunction

  function automatic logic [129:0] pack_exp(input exp_t e);
    return {e.ir, e.pc, e.alu, e.lmd, e.mis, e.berr};
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] d);
    logic [7:0]  by;
    logic [15:0] hw;
    by = d[8*a +: 8];
    hw = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  return {{24{by[7]}}, by};
      3'b100:  return {24'h0, by};
      3'b001:  return {{16{hw[15]}}, hw};
      3'b101:  return {16'h0, hw};
      default: return d;
    endcase
  endfunction

  // Drive one instruction, act as data memory (ack on REQ cycle ack_at, 0 = never),
  // and record latency, REQ cycle count and bus fields.
  task automatic run_op(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] b, input int ack_at, input logic [31:0] rdata);
    obs_lat    = -1;
    obs_req    = 0;
    obs_stable = 1'b1;
    obs_pulse1 = 1'b0;
    obs_ready  = 1'b0;
    obs_we     = 1'b0;
    obs_addr   = 32'h0;
    obs_wdata  = 32'h0;
    obs_be     = 4'h0;
    @(negedge clk);
    bus.ex_mem_ir      = ir;
    bus.ex_mem_pc      = pc;
    bus.ex_mem_alu_out = alu;
    bus.ex_mem_b       = b;
    bus.ex_mem_valid   = 1'b1;
    @(posedge clk);
    #1 bus.ex_mem_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      bus.dmem_ack = 1'b0;
      if (bus.dmem_req) begin
        obs_req++;
        if (obs_req == 1) begin
          obs_we    = bus.dmem_we;
          obs_addr  = bus.dmem_addr;
          obs_wdata = bus.dmem_wdata;
          obs_be    = bus.dmem_be;
        end else if (bus.dmem_we !== obs_we || bus.dmem_addr !== obs_addr ||
                     bus.dmem_wdata !== obs_wdata || bus.dmem_be !== obs_be) begin
          obs_stable = 1'b0;
        end
        if (obs_req == ack_at) begin
          bus.dmem_ack   = 1'b1;
          bus.dmem_rdata = rdata;
        end
      end
      if (bus.mem_wb_valid) begin
        obs_lat = cyc;
        break;
      end
    end
    bus.dmem_ack = 1'b0;
    if (obs_lat > 0) begin
      @(negedge clk);
      obs_pulse1 = !bus.mem_wb_valid;
      obs_ready  = bus.ex_mem_ready;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3 rst = 1'b0;
    #2;
    checks++;
    if (bus.ex_mem_ready !== 1'b1)
      $display("FAIL reset_ready: got %b want 1", bus.ex_mem_ready);
    else checks += 0;
    if (bus.ex_mem_ready !== 1'b1) errors++;
    checks++;
    if ({bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_addr, bus.dmem_wdata} !== 70'h0) begin
      $display("FAIL reset_bus: req=%b we=%b be=%h addr=%h wdata=%h want all 0",
               bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_addr, bus.dmem_wdata);
      errors++;
    end
    checks++;
    if (bus.mem_wb_valid !== 1'b0 || wb_now() !== 130'h0) begin
      $display("FAIL reset_wb: valid=%b wb=%h want 0", bus.mem_wb_valid, wb_now());
      errors++;
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_common(input string name, input int exp_lat, input int exp_req);
    exp_t e;
    checks++;
    if (obs_lat !== exp_lat) begin
      $display("FAIL %s_latency: got %0d want %0d", name, obs_lat, exp_lat);
      errors++;
    end
    checks++;
    if (obs_req !== exp_req) begin
      $display("FAIL %s_req_cycles: got %0d want %0d", name, obs_req, exp_req);
      errors++;
    end
    checks++;
    if (!obs_pulse1 || obs_ready !== 1'b1) begin
      $display("FAIL %s_pulse: one_cycle=%b ready_after=%b want 1 1", name, obs_pulse1, obs_ready);
      errors++;
    end
    checks++;
    if (sb.size() == 0) begin
      $display("FAIL %s_scoreboard: got empty queue want entry", name);
      errors++;
    end else begin
      e = sb.pop_front();
      if (wb_now() !== pack_exp(e)) begin
        $display("FAIL %s_wb: got %h want %h", name, wb_now(), pack_exp(e));
        errors++;
      end
    end
  endtask

  task automatic test_passthrough();
    logic [31:0] ir;
    ir = mk_ir(OP_ALU, 3'b000);
    sb.push_back('{ir, 32'h40, 32'h1234, 32'h0, 1'b0, 1'b0});
    run_op(ir, 32'h40, 32'h1234, 32'hDEAD_BEEF, 1, 32'h0);
    check_common("add_pass", 1, 0);
    ir = mk_ir(OP_STORE, 3'b011);
    sb.push_back('{ir, 32'h44, 32'h0000_0300, 32'h0, 1'b0, 1'b0});
    run_op(ir, 32'h44, 32'h0000_0300, 32'h1111_2222, 1, 32'h0);
    check_common("bad_f3_pass", 1, 0);
  endtask

  task automatic test_load();
    logic [31:0] ir;
    logic [31:0] d;
    logic [31:0] a;
    logic [2:0]  f3s [4];
    ir = mk_ir(OP_LOAD, 3'b000);
    sb.push_back('{ir, 32'h80, 32'h103, 32'hFFFF_FF80, 1'b0, 1'b0});
    run_op(ir, 32'h80, 32'h103, 32'h0, 1, 32'h80FF_0000);
    check_common("lb", 2, 1);
    checks++;
    if (obs_addr !== 32'h100 || obs_be !== 4'hF || obs_we !== 1'b0) begin
      $display("FAIL lb_bus: addr=%h be=%h we=%b want 00000100 f 0", obs_addr, obs_be, obs_we);
      errors++;
    end
    ir = mk_ir(OP_LOAD, 3'b100);
    sb.push_back('{ir, 32'h84, 32'h103, 32'h0000_0080, 1'b0, 1'b0});
    run_op(ir, 32'h84, 32'h103, 32'h0, 1, 32'h80FF_0000);
    check_common("lbu", 2, 1);
    f3s = '{3'b000, 3'b100, 3'b001, 3'b101};
    for (int k = 0; k < 4; k++) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (f3s[k][0] && lane[0]) continue;
        d  = $urandom;
        a  = 32'h2000 + 32'(lane);
        ir = mk_ir(OP_LOAD, f3s[k]);
        sb.push_back('{ir, 32'h100 + 32'(4 * lane), a, model_load(f3s[k], a[1:0], d), 1'b0, 1'b0});
        run_op(ir, 32'h100 + 32'(4 * lane), a, 32'h0, 1 + (lane % 3), d);
        check_common("load_lane", 2 + (lane % 3), 1 + (lane % 3));
      end
    end
    ir = mk_ir(OP_LOAD, 3'b010);
    sb.push_back('{ir, 32'h200, 32'h3008, 32'hCAFE_F00D, 1'b0, 1'b0});
    run_op(ir, 32'h200, 32'h3008, 32'h0, 2, 32'hCAFE_F00D);
    check_common("lw", 3, 2);
  endtask

  task automatic test_store();
    logic [31:0] ir;
    ir = mk_ir(OP_STORE, 3'b001);
    sb.push_back('{ir, 32'h300, 32'h102, 32'h0, 1'b0, 1'b0});
    run_op(ir, 32'h300, 32'h102, 32'hABCD_1234, 3, 32'h5555_5555);
    check_common("sh", 4, 3);
    checks++;
    if (obs_be !== 4'b1100 || obs_wdata !== 32'h1234_1234 || obs_we !== 1'b1 ||
        obs_addr !== 32'h100 || !obs_stable) begin
      $display("FAIL sh_bus: be=%b wdata=%h we=%b addr=%h stable=%b want 1100 12341234 1 00000100 1",
               obs_be, obs_wdata, obs_we, obs_addr, obs_stable);
      errors++;
    end
    ir = mk_ir(OP_STORE, 3'b000);
    sb.push_back('{ir, 32'h304, 32'h401, 32'h0, 1'b0, 1'b0});
    run_op(ir, 32'h304, 32'h401, 32'h0000_775A, 2, 32'h0);
    check_common("sb", 3, 2);
    checks++;
    if (obs_be !== 4'b0010 || obs_wdata !== 32'h5A5A_5A5A || obs_addr !== 32'h400) begin
      $display("FAIL sb_bus: be=%b wdata=%h addr=%h want 0010 5a5a5a5a 00000400",
               obs_be, obs_wdata, obs_addr);
      errors++;
    end
    ir = mk_ir(OP_STORE, 3'b010);
    sb.push_back('{ir, 32'h308, 32'h500, 32'h0, 1'b0, 1'b0});
    run_op(ir, 32'h308, 32'h500, 32'h8765_4321, 1, 32'h0);
    check_common("sw", 2, 1);
    checks++;
    if (obs_be !== 4'hF || obs_wdata !== 32'h8765_4321 || obs_we !== 1'b1) begin
      $display("FAIL sw_bus: be=%h wdata=%h we=%b want f 87654321 1", obs_be, obs_wdata, obs_we);
      errors++;
    end
  endtask

  task automatic test_misalign();
    logic [31:0] ir;
    ir = mk_ir(OP_LOAD, 3'b010);
    sb.push_back('{ir, 32'h600, 32'h101, 32'h0, 1'b1, 1'b0});
    run_op(ir, 32'h600, 32'h101, 32'h0, 1, 32'hFFFF_FFFF);
    check_common("lw_misalign", 1, 0);
    sb.push_back('{ir, 32'h604, 32'h104, 32'h1357_9BDF, 1'b0, 1'b0});
    run_op(ir, 32'h604, 32'h104, 32'h0, 1, 32'h1357_9BDF);
    check_common("lw_aligned", 2, 1);
    ir = mk_ir(OP_STORE, 3'b001);
    sb.push_back('{ir, 32'h608, 32'h103, 32'h0, 1'b1, 1'b0});
    run_op(ir, 32'h608, 32'h103, 32'hFFFF, 1, 32'h0);
    check_common("sh_misalign", 1, 0);
  endtask

  task automatic test_timeout();
    logic [31:0] ir;
    ir = mk_ir(OP_STORE, 3'b010);
    sb.push_back('{ir, 32'h700, 32'h800, 32'h0, 1'b0, 1'b1});
    run_op(ir, 32'h700, 32'h800, 32'h2468_ACE0, 0, 32'h0);
    check_common("sw_timeout", 17, 16);
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.dmem_req !== 1'b0 || bus.mem_wb_valid !== 1'b0 || bus.ex_mem_ready !== 1'b1) begin
        $display("FAIL late_ack: req=%b valid=%b ready=%b want 0 0 1",
                 bus.dmem_req, bus.mem_wb_valid, bus.ex_mem_ready);
        errors++;
      end
    end
    bus.dmem_ack = 1'b0;
    ir = mk_ir(OP_LOAD, 3'b101);
    sb.push_back('{ir, 32'h704, 32'h902, 32'h0000_F00F, 1'b0, 1'b0});
    run_op(ir, 32'h704, 32'h902, 32'h0, 2, 32'hF00F_0000);
    check_common("after_timeout", 3, 2);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] ir1;
    logic [31:0] ir2;
    ir1 = mk_ir(OP_ALU, 3'b111);
    ir2 = mk_ir(OP_ALU, 3'b110);
    @(negedge clk);
    bus.ex_mem_ir = ir1; bus.ex_mem_pc = 32'hA00; bus.ex_mem_alu_out = 32'h11; bus.ex_mem_b = 32'h0;
    bus.ex_mem_valid = 1'b1;
    sb.push_back('{ir1, 32'hA00, 32'h11, 32'h0, 1'b0, 1'b0});
    @(negedge clk);
    checks++;
    if (bus.ex_mem_ready !== 1'b0 || bus.mem_wb_valid !== 1'b1) begin
      $display("FAIL b2b_first: ready=%b valid=%b want 0 1", bus.ex_mem_ready, bus.mem_wb_valid);
      errors++;
    end
    checks++;
    e = sb.pop_front();
    if (wb_now() !== pack_exp(e)) begin
      $display("FAIL b2b_first_wb: got %h want %h", wb_now(), pack_exp(e));
      errors++;
    end
    bus.ex_mem_ir = ir2; bus.ex_mem_pc = 32'hA04; bus.ex_mem_alu_out = 32'h22;
    sb.push_back('{ir2, 32'hA04, 32'h22, 32'h0, 1'b0, 1'b0});
    @(negedge clk);
    checks++;
    if (bus.ex_mem_ready !== 1'b1 || bus.mem_wb_valid !== 1'b0 || bus.mem_wb_ir !== ir1) begin
      $display("FAIL b2b_gap: ready=%b valid=%b ir=%h want 1 0 %h",
               bus.ex_mem_ready, bus.mem_wb_valid, bus.mem_wb_ir, ir1);
      errors++;
    end
    @(posedge clk);
    #1 bus.ex_mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    e = sb.pop_front();
    if (bus.mem_wb_valid !== 1'b1 || wb_now() !== pack_exp(e)) begin
      $display("FAIL b2b_second: valid=%b wb=%h want 1 %h", bus.mem_wb_valid, wb_now(), pack_exp(e));
      errors++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] ir;
    int pulses;
    ir = mk_ir(OP_STORE, 3'b010);
    @(negedge clk);
    bus.ex_mem_ir = ir; bus.ex_mem_pc = 32'hB00; bus.ex_mem_alu_out = 32'hC00;
    bus.ex_mem_b = 32'h0F0F_0F0F; bus.ex_mem_valid = 1'b1;
    @(posedge clk);
    #1 bus.ex_mem_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.dmem_req !== 1'b1) begin
      $display("FAIL rst_mid_req_before: got %b want 1", bus.dmem_req);
      errors++;
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || bus.ex_mem_ready !== 1'b1) begin
      $display("FAIL rst_mid_async: req=%b ready=%b want 0 1", bus.dmem_req, bus.ex_mem_ready);
      errors++;
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.mem_wb_valid) pulses++;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.mem_wb_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      $display("FAIL rst_mid_no_valid: got %0d pulses want 0", pulses);
      errors++;
    end
    ir = mk_ir(OP_ALU, 3'b000);
    sb.push_back('{ir, 32'hB04, 32'h5A5A, 32'h0, 1'b0, 1'b0});
    run_op(ir, 32'hB04, 32'h5A5A, 32'h0, 1, 32'h0);
    check_common("after_rst", 1, 0);
  endtask

  initial begin
    bus.ex_mem_valid   = 1'b0;
    bus.ex_mem_alu_out = 32'h0;
    bus.ex_mem_b       = 32'h0;
    bus.ex_mem_ir      = 32'h0;
    bus.ex_mem_pc      = 32'h0;
    bus.dmem_rdata     = 32'h0;
    bus.dmem_ack       = 1'b0;
    test_reset();
    test_passthrough();
    test_load();
    test_store();
    test_misalign();
    test_timeout();
    test_back_to_back();
    test_reset_mid_op();
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
      errors++;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
